fetch_stage: RTL and testbench

- Instruction-fetch stage directly upstream of the ID stage of the 5-stage MIPS pipeline.
- Owns the PC, issues word fetches over a req/ack instruction-memory handshake, and buffers returned instructions in a small queue.
- Drives the IF/ID pipeline register (instruction, PC+4, valid) consumed by decode.
- Honours hazard-unit stalls and ID-stage branch redirects/flushes.

---
 rtl/cpu_pkg.sv | 25 ++
 rtl/fetch_queue.sv | 50 +++++
 rtl/fetch_stage.sv | 118 +++++++++++
 tb/tb_fetch_stage.sv | 379 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared types and constants for the MIPS pipeline front end.
// Holds the fetch FSM encoding and the IF/ID register bundle.
package cpu_pkg;

   localparam logic [31:0] INST_NOP        = 32'h0000_0000;
   localparam logic [31:0] WORD_BYTES      = 32'd4;
   localparam int unsigned IF_ID_PAYLOAD_W = 64;

   typedef enum logic [1:0] {
      StIdle,
      StFetch,
      StDrain
   } fetch_state_e;

   typedef struct packed {
      logic        valid;
      logic [31:0] inst;
      logic [31:0] pc4;
   } if_id_t;

   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return addr & ~32'h3;
   endfunction

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO buffering fetched {instruction, pc+4} pairs.
// Clear and reset are synchronous; push and pop may coincide at any occupancy.
module fetch_queue import cpu_pkg::*; #(
   parameter int unsigned QDEPTH = 2,
   parameter int unsigned WIDTH  = IF_ID_PAYLOAD_W
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    clear_i,
   input  logic                    push_i,
   input  logic [WIDTH-1:0]        wdata_i,
   input  logic                    pop_i,
   output logic [WIDTH-1:0]        rdata_o,
   output logic [$clog2(QDEPTH):0] count_o,
   output logic                    full_o,
   output logic                    empty_o
);

   localparam int unsigned PW = $clog2(QDEPTH);

   logic [WIDTH-1:0] mem_q [QDEPTH];
   logic [PW-1:0]    wptr_q, rptr_q;
   logic [PW:0]      count_q;
   logic             do_push, do_pop;

   assign empty_o = (count_q == '0);
   assign full_o  = (count_q == (PW+1)'(QDEPTH));
   assign do_pop  = pop_i && !empty_o;
   // A full queue still takes a push when the head is popped in the same cycle.
   assign do_push = push_i && (!full_o || do_pop);
   assign rdata_o = mem_q[rptr_q];
   assign count_o = count_q;

   always_ff @(posedge clk_i) begin
      if (rst_i || clear_i) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         if (do_push) wptr_q <= wptr_q + 1'b1;
         if (do_pop)  rptr_q <= rptr_q + 1'b1;
         count_q <= count_q + {{PW{1'b0}}, do_push} - {{PW{1'b0}}, do_pop};
      end
   end

   always_ff @(posedge clk_i) begin
      if (do_push) mem_q[wptr_q] <= wdata_i;
   end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, runs the imem req/ack handshake,
// queues returned words and drives the IF/ID register for decode.
module fetch_stage import cpu_pkg::*; #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned QDEPTH   = 2,
   parameter logic [31:0] INST_NOP = cpu_pkg::INST_NOP
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        start_i,
   input  logic        stall_i,
   input  logic        flush_i,
   input  logic [31:0] branch_target_i,
   output logic        imem_req_o,
   output logic [31:0] imem_addr_o,
   input  logic        imem_ack_i,
   input  logic [31:0] imem_data_i,
   output logic        if_id_valid_o,
   output logic [31:0] if_id_inst_o,
   output logic [31:0] if_id_pc_o
);

   localparam int unsigned CW = $clog2(QDEPTH) + 1;
   localparam if_id_t IfIdBubble = '{valid: 1'b0, inst: INST_NOP, pc4: 32'h0};

   fetch_state_e state_q;
   logic [31:0]  pc_q, drain_addr_q;
   logic         pending_q;
   if_id_t       if_id_q;

   logic          q_push, q_pop, q_full, q_empty;
   logic [CW-1:0] q_count;
   logic [63:0]   q_head;
   logic          ack, good_ack, bypass, hold_req;
   logic          unused_count;

   always_comb begin
      imem_req_o = 1'b0;
      unique case (state_q)
         StIdle:  imem_req_o = 1'b0;
         StFetch: imem_req_o = pending_q || (start_i && !q_full);
         StDrain: imem_req_o = 1'b1;
         default: imem_req_o = 1'b0;
      endcase
   end

   assign imem_addr_o = (state_q == StDrain) ? drain_addr_q : pc_q;
   assign ack         = imem_req_o && imem_ack_i;
   assign hold_req    = imem_req_o && !imem_ack_i;
   // Data returned for a squashed (draining or flushed) request is dropped.
   assign good_ack    = ack && (state_q == StFetch) && !flush_i;
   assign q_pop       = !flush_i && !stall_i && !q_empty;
   assign bypass      = !flush_i && !stall_i && q_empty && good_ack;
   assign q_push      = good_ack && !bypass;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q      <= StIdle;
         pc_q         <= RESET_PC;
         drain_addr_q <= RESET_PC;
         pending_q    <= 1'b0;
         if_id_q      <= IfIdBubble;
      end else begin
         pending_q <= hold_req;

         if (flush_i)       pc_q <= word_align(branch_target_i);
         else if (good_ack) pc_q <= pc_q + WORD_BYTES;

         if (flush_i) begin
            if_id_q <= IfIdBubble;
         end else if (!stall_i) begin
            if (q_pop)       if_id_q <= {1'b1, q_head};
            else if (bypass) if_id_q <= {1'b1, imem_data_i, pc_q + WORD_BYTES};
            else             if_id_q <= IfIdBubble;
         end

         unique case (state_q)
            StIdle: begin
               if (start_i) state_q <= StFetch;
            end
            StFetch: begin
               if (flush_i && hold_req) begin
                  state_q      <= StDrain;
                  drain_addr_q <= pc_q;
               end else if (!flush_i && !start_i && !hold_req) begin
                  state_q <= StIdle;
               end
            end
            StDrain: begin
               if (ack) state_q <= StFetch;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   fetch_queue #(
      .QDEPTH (QDEPTH),
      .WIDTH  (IF_ID_PAYLOAD_W)
   ) u_queue (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .clear_i (flush_i),
      .push_i  (q_push),
      .wdata_i ({imem_data_i, pc_q + WORD_BYTES}),
      .pop_i   (q_pop),
      .rdata_o (q_head),
      .count_o (q_count),
      .full_o  (q_full),
      .empty_o (q_empty)
   );

   assign unused_count  = ^q_count;
   assign if_id_valid_o = if_id_q.valid;
   assign if_id_inst_o  = if_id_q.inst;
   assign if_id_pc_o    = if_id_q.pc4;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus random traffic,
// all checked cycle by cycle against a queue-based reference model.
module tb_fetch_stage;

   localparam int          QDEPTH   = 2;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam logic [31:0] NOP      = 32'h0000_0000;

   logic        clk, rst, start, stall, flush;
   logic [31:0] target;
   logic        imem_req, imem_ack;
   logic [31:0] imem_addr, imem_data;
   logic        if_id_valid;
   logic [31:0] if_id_inst, if_id_pc;

   int nchecks = 0;
   int nerrors = 0;

   // Reference model state
   logic [63:0] mq[$];
   logic        m_valid, m_drain, m_pend;
   logic [31:0] m_inst, m_pc4, m_pc, m_drain_addr;
   int          m_wait;

   logic [31:0] prog [16] = '{
      32'h2008_0005, 32'h2009_0003, 32'h012A_4020, 32'h8D0B_0004,
      32'hAD0C_0008, 32'h1109_FFFB, 32'h0009_4040, 32'h3C0D_1234,
      32'h35AD_5678, 32'h01AE_7822, 32'h0810_000C, 32'h240E_0001,
      32'h000E_7880, 32'h01CF_7825, 32'hAC0F_0010, 32'h0800_0000
   };

   fetch_stage #(
      .RESET_PC (RESET_PC),
      .QDEPTH   (QDEPTH),
      .INST_NOP (NOP)
   ) dut (
      .clk_i           (clk),
      .rst_i           (rst),
      .start_i         (start),
      .stall_i         (stall),
      .flush_i         (flush),
      .branch_target_i (target),
      .imem_req_o      (imem_req),
      .imem_addr_o     (imem_addr),
      .imem_ack_i      (imem_ack),
      .imem_data_i     (imem_data),
      .if_id_valid_o   (if_id_valid),
      .if_id_inst_o    (if_id_inst),
      .if_id_pc_o      (if_id_pc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a < 32'h40) return prog[a[5:2]];
      return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
   endfunction

   task automatic model_reset();
      mq.delete();
      m_valid = 1'b0; m_inst = NOP; m_pc4 = 32'h0;
      m_pc = RESET_PC; m_drain = 1'b0; m_drain_addr = 32'h0;
      m_pend = 1'b0; m_wait = 0;
   endtask

   task automatic do_reset(input logic st);
      rst = 1'b1; start = st; stall = 1'b0; flush = 1'b0; imem_ack = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      model_reset();
      @(negedge clk);
   endtask

   // One clock of stimulus; protocol checked before the edge, IF/ID after it.
   task automatic step(input logic st, input logic sl, input logic fl,
                       input logic [31:0] tg, input logic ack_en);
      logic        req_s, ack_s, was_empty, discard;
      logic [31:0] addr_s, data_s, exp_addr;
      start = st; stall = sl; flush = fl; target = tg;
      #1;
      req_s = imem_req; addr_s = imem_addr;
      exp_addr = m_drain ? m_drain_addr : m_pc;
      if (m_pend || m_drain) begin
         nchecks++;
         if (req_s !== 1'b1) begin
            nerrors++;
            $display("FAIL req_hold: req got %b expected 1", req_s);
         end
      end else if (req_s === 1'b1) begin
         nchecks++;
         if (!(st && mq.size() < QDEPTH)) begin
            nerrors++;
            $display("FAIL req_allowed: req got 1 expected 0 (start %b occ %0d)", st, mq.size());
         end
      end
      if (req_s === 1'b1) begin
         nchecks++;
         if (addr_s !== exp_addr) begin
            nerrors++;
            $display("FAIL req_addr: addr got %h expected %h", addr_s, exp_addr);
         end
      end
      if (st && req_s !== 1'b1 && !m_drain && mq.size() < QDEPTH) m_wait++;
      else m_wait = 0;
      if (st) begin
         nchecks++;
         if (m_wait > 2) begin
            nerrors++;
            $display("FAIL req_liveness: idle cycles got %0d expected <= 2", m_wait);
         end
      end
      ack_s  = ack_en && (req_s === 1'b1);
      data_s = ack_s ? mem_word(addr_s) : $urandom;
      imem_ack = ack_s; imem_data = data_s;
      @(posedge clk);
      discard   = fl || m_drain;
      was_empty = (mq.size() == 0);
      if (fl) begin
         mq.delete();
         m_valid = 1'b0; m_inst = NOP; m_pc4 = 32'h0;
      end else if (!sl) begin
         if (!was_empty) begin
            {m_inst, m_pc4} = mq.pop_front();
            m_valid = 1'b1;
         end else if (ack_s && !discard) begin
            m_inst = data_s; m_pc4 = addr_s + 32'd4; m_valid = 1'b1;
         end else begin
            m_valid = 1'b0; m_inst = NOP; m_pc4 = 32'h0;
         end
      end
      if (ack_s && !discard && !(was_empty && !sl)) mq.push_back({data_s, addr_s + 32'd4});
      if (fl) m_pc = tg & ~32'h3;
      else if (ack_s && !m_drain) m_pc = m_pc + 32'd4;
      if (fl && req_s && !ack_s) begin
         if (!m_drain) m_drain_addr = addr_s;
         m_drain = 1'b1;
      end else if (ack_s) begin
         m_drain = 1'b0;
      end
      m_pend = req_s && !ack_s;
      #1;
      imem_ack = 1'b0;
      nchecks++;
      if ({if_id_valid, if_id_inst, if_id_pc} !== {m_valid, m_inst, m_pc4}) begin
         nerrors++;
         $display("FAIL if_id: got v=%b inst=%h pc=%h expected v=%b inst=%h pc=%h",
                  if_id_valid, if_id_inst, if_id_pc, m_valid, m_inst, m_pc4);
      end
      @(negedge clk);
   endtask

   task automatic test_reset();
      do_reset(1'b0);
      nchecks++;
      if ({imem_req, if_id_valid, if_id_inst, if_id_pc} !== {1'b0, 1'b0, NOP, 32'h0}) begin
         nerrors++;
         $display("FAIL reset_outputs: got req=%b v=%b inst=%h pc=%h expected 0 0 %h 0",
                  imem_req, if_id_valid, if_id_inst, if_id_pc, NOP);
      end
      step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
      nchecks++;
      if (imem_req !== 1'b0) begin
         nerrors++;
         $display("FAIL idle_no_req: req got %b expected 0", imem_req);
      end
   endtask

   task automatic test_stream();
      do_reset(1'b0);
      step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
      nchecks++;
      if (if_id_valid !== 1'b0) begin
         nerrors++;
         $display("FAIL stream_first_bubble: valid got %b expected 0", if_id_valid);
      end
      step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
      nchecks++;
      if ({if_id_valid, if_id_inst, if_id_pc} !== {1'b1, 32'h2008_0005, 32'd4}) begin
         nerrors++;
         $display("FAIL stream_first: got v=%b inst=%h pc=%h expected 1 20080005 00000004",
                  if_id_valid, if_id_inst, if_id_pc);
      end
      step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
      nchecks++;
      if ({if_id_valid, if_id_inst, if_id_pc} !== {1'b1, 32'h2009_0003, 32'd8}) begin
         nerrors++;
         $display("FAIL stream_second: got v=%b inst=%h pc=%h expected 1 20090003 00000008",
                  if_id_valid, if_id_inst, if_id_pc);
      end
      repeat (5) step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
   endtask

   task automatic test_stall();
      logic [63:0] held;
      do_reset(1'b0);
      step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
      step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
      held = {if_id_inst, if_id_pc};
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
         nchecks++;
         if ({if_id_valid, if_id_inst, if_id_pc} !== {1'b1, 32'h2008_0005, 32'd4}) begin
            nerrors++;
            $display("FAIL stall_freeze: got inst=%h pc=%h expected %h", if_id_inst, if_id_pc, held);
         end
      end
      #1;
      nchecks++;
      if (imem_req !== 1'b0) begin
         nerrors++;
         $display("FAIL stall_full_req: req got %b expected 0", imem_req);
      end
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
         nchecks++;
         if (if_id_pc !== 32'd8 + 32'(4 * i) || if_id_valid !== 1'b1) begin
            nerrors++;
            $display("FAIL stall_release: pc got %h expected %h", if_id_pc, 32'd8 + 32'(4 * i));
         end
      end
   endtask

   task automatic test_ack_delay();
      bit found = 0;
      do_reset(1'b0);
      step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
      for (int i = 0; i < 10 && !found; i++) begin
         if (imem_req === 1'b1 && imem_addr === 32'h10) found = 1;
         else step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
      end
      nchecks++;
      if (!found) begin
         nerrors++;
         $display("FAIL delay_reach: addr got %h expected 00000010", imem_addr);
      end
      for (int i = 0; i < 4; i++) begin
         step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
         nchecks++;
         if (imem_req !== 1'b1 || imem_addr !== 32'h10) begin
            nerrors++;
            $display("FAIL delay_hold: req=%b addr=%h expected 1 00000010", imem_req, imem_addr);
         end
      end
      step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
      nchecks++;
      if ({if_id_valid, if_id_inst, if_id_pc} !== {1'b1, mem_word(32'h10), 32'h14}) begin
         nerrors++;
         $display("FAIL delay_deliver: got v=%b inst=%h pc=%h expected 1 %h 00000014",
                  if_id_valid, if_id_inst, if_id_pc, mem_word(32'h10));
      end
      repeat (3) step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
   endtask

   task automatic test_flush_drain();
      bit found = 0;
      do_reset(1'b0);
      step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
      for (int i = 0; i < 12 && !found; i++) begin
         if (imem_req === 1'b1 && imem_addr === 32'h18) found = 1;
         else step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
      end
      step(1'b1, 1'b0, 1'b1, 32'h40, 1'b0);
      step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
      nchecks++;
      if (!found || imem_req !== 1'b1 || imem_addr !== 32'h18 || if_id_valid !== 1'b0) begin
         nerrors++;
         $display("FAIL drain_hold: req=%b addr=%h v=%b expected 1 00000018 0",
                  imem_req, imem_addr, if_id_valid);
      end
      step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
      nchecks++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h40 || if_id_valid !== 1'b0) begin
         nerrors++;
         $display("FAIL drain_redirect: req=%b addr=%h v=%b expected 1 00000040 0",
                  imem_req, imem_addr, if_id_valid);
      end
      step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
      nchecks++;
      if (if_id_valid !== 1'b1 || if_id_pc !== 32'h44) begin
         nerrors++;
         $display("FAIL drain_deliver: v=%b pc=%h expected 1 00000044", if_id_valid, if_id_pc);
      end
   endtask

   task automatic test_flush_stall_ack();
      do_reset(1'b0);
      step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
      step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
      step(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
      step(1'b1, 1'b1, 1'b1, 32'h83, 1'b1);
      nchecks++;
      if ({if_id_valid, if_id_inst, if_id_pc} !== {1'b0, NOP, 32'h0}) begin
         nerrors++;
         $display("FAIL flush_wins: got v=%b inst=%h pc=%h expected 0 %h 0",
                  if_id_valid, if_id_inst, if_id_pc, NOP);
      end
      #1;
      nchecks++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h80) begin
         nerrors++;
         $display("FAIL flush_target: req=%b addr=%h expected 1 00000080", imem_req, imem_addr);
      end
      step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
      nchecks++;
      if (if_id_valid !== 1'b1 || if_id_pc !== 32'h84) begin
         nerrors++;
         $display("FAIL flush_queue_cleared: v=%b pc=%h expected 1 00000084", if_id_valid, if_id_pc);
      end
   endtask

   task automatic test_wrap();
      do_reset(1'b0);
      step(1'b1, 1'b0, 1'b1, 32'hFFFF_FFF8, 1'b0);
      step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
      step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
      nchecks++;
      if (if_id_valid !== 1'b1 || if_id_pc !== 32'h0 || imem_addr !== 32'h0) begin
         nerrors++;
         $display("FAIL pc_wrap: v=%b pc=%h addr=%h expected 1 00000000 00000000",
                  if_id_valid, if_id_pc, imem_addr);
      end
   endtask

   task automatic test_reset_mid();
      do_reset(1'b0);
      step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
      repeat (3) step(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
      do_reset(1'b1);
      nchecks++;
      if ({imem_req, if_id_valid, if_id_inst, if_id_pc} !== {1'b0, 1'b0, NOP, 32'h0}) begin
         nerrors++;
         $display("FAIL reset_mid: got req=%b v=%b inst=%h pc=%h expected 0 0 %h 0",
                  imem_req, if_id_valid, if_id_inst, if_id_pc, NOP);
      end
      step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
      nchecks++;
      if (imem_req !== 1'b1 || imem_addr !== RESET_PC) begin
         nerrors++;
         $display("FAIL reset_restart: req=%b addr=%h expected 1 %h", imem_req, imem_addr, RESET_PC);
      end
   endtask

   task automatic test_random();
      logic [31:0] tg;
      do_reset(1'b0);
      for (int i = 0; i < 400; i++) begin
         tg = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF))
                                          : ($urandom & 32'h0000_01FF);
         step($urandom_range(0, 9) != 0, $urandom_range(0, 3) == 0,
              $urandom_range(0, 15) == 0, tg, $urandom_range(0, 2) != 0);
      end
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; stall = 1'b0; flush = 1'b0;
      target = 32'h0; imem_ack = 1'b0; imem_data = 32'h0;
      model_reset();
      @(negedge clk);
      test_reset();
      test_stream();
      test_stall();
      test_ack_delay();
      test_flush_drain();
      test_flush_stall_ack();
      test_wrap();
      test_reset_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached before the summary");
      $fatal(1, "watchdog");
   end

endmodule
